// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the two-requester SCCB arbiter.
// Holds the FSM encoding, the SCCB field width and the requester indices.
package sccb_arb_pkg;

    localparam int DATA_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sccb_req_slot.sv
// One-entry command buffer for a single SCCB requester.
// Accepts a pulse only while empty; the arbiter clears it on completion or abort.
module sccb_req_slot
    import sccb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              pending,
    output logic              is_rd,
    output logic [DATA_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_wdata,
    output logic              rdy
);

    logic accept;

    assign accept = (wr_en | rd_en) & ~pending;
    assign rdy    = ~pending;

    // clr and accept never coincide: clr only hits a full slot, accept only an empty one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            is_rd      <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
        end else begin
            if (clr)
                pending <= 1'b0;
            else if (accept)
                pending <= 1'b1;

            if (accept) begin
                is_rd      <= rd_en & ~wr_en;
                slot_addr  <= addr;
                slot_wdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one SCCB master between the power-up config engine (req0) and the
// runtime register port (req1): round-robin grant, lock to req0, start timeout.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | waiting for master idle and an eligible pending slot
// ST_ISSUE      | one-cycle wr_en/rd_en pulse to the master
// ST_WAIT_START | waiting for master rdy to fall; abort after START_TIMEOUT
// ST_WAIT_DONE  | master busy; rdy rising completes the owner's command
module sccb_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int START_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_wr_en,
    input  logic              req0_rd_en,
    input  logic [DATA_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              req0_rdy,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_rdata_vld,

    input  logic              req1_wr_en,
    input  logic              req1_rd_en,
    input  logic [DATA_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_rdy,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_rdata_vld,

    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              rdy,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rdata_vld,
    output logic              err
);

    localparam int              TMO_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(START_TIMEOUT);

    arb_state_t state, state_nxt;

    logic              pend0, pend1;
    logic              is_rd0, is_rd1;
    logic [DATA_W-1:0] slot_addr0, slot_addr1;
    logic [DATA_W-1:0] slot_wdata0, slot_wdata1;
    logic              clr0, clr1;

    logic              owner;
    logic              last;
    logic              cmd_rd;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              elig0, elig1;
    logic              grant;
    logic              sel;
    logic              done;
    logic              tmo_hit;
    logic              busy;
    logic              fwd0, fwd1;

    sccb_req_slot u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (req0_wr_en),
        .rd_en      (req0_rd_en),
        .addr       (req0_addr),
        .wdata      (req0_wdata),
        .clr        (clr0),
        .pending    (pend0),
        .is_rd      (is_rd0),
        .slot_addr  (slot_addr0),
        .slot_wdata (slot_wdata0),
        .rdy        (req0_rdy)
    );

    sccb_req_slot u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (req1_wr_en),
        .rd_en      (req1_rd_en),
        .addr       (req1_addr),
        .wdata      (req1_wdata),
        .clr        (clr1),
        .pending    (pend1),
        .is_rd      (is_rd1),
        .slot_addr  (slot_addr1),
        .slot_wdata (slot_wdata1),
        .rdy        (req1_rdy)
    );

    assign elig0   = pend0;
    assign elig1   = pend1 & ~req0_lock;
    assign grant   = (state == ST_IDLE) & rdy & (elig0 | elig1);
    assign done    = (state == ST_WAIT_DONE) & rdy;
    assign tmo_hit = (state == ST_WAIT_START) & rdy & (tmo_cnt == '0);
    assign busy    = (state == ST_WAIT_START) | (state == ST_WAIT_DONE);

    assign clr0 = (done | tmo_hit) & (owner == REQ0);
    assign clr1 = (done | tmo_hit) & (owner == REQ1);

    // On a tie the requester that did not complete last wins
    always_comb begin
        sel = REQ0;
        if (elig0 & elig1)
            sel = ~last;
        else if (elig1)
            sel = REQ1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant)
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!rdy)
                    state_nxt = ST_WAIT_DONE;
                else if (tmo_cnt == '0)
                    state_nxt = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (rdy)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        err   = tmo_hit;
        if (state == ST_ISSUE) begin
            rd_en = cmd_rd;
            wr_en = ~cmd_rd;
        end
    end

    // Command fields stay on the bus from grant until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= REQ0;
            last    <= REQ1;
            cmd_rd  <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            tmo_cnt <= '0;
        end else begin
            if (grant) begin
                owner  <= sel;
                cmd_rd <= sel ? is_rd1 : is_rd0;
                addr   <= sel ? slot_addr1 : slot_addr0;
                wdata  <= sel ? slot_wdata1 : slot_wdata0;
            end

            if (done)
                last <= owner;

            if (state == ST_ISSUE)
                tmo_cnt <= TMO_LOAD;
            else if ((state == ST_WAIT_START) && (tmo_cnt != '0))
                tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    assign fwd0 = rdata_vld & busy & (owner == REQ0);
    assign fwd1 = rdata_vld & busy & (owner == REQ1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_rdata     <= '0;
            req0_rdata_vld <= 1'b0;
            req1_rdata     <= '0;
            req1_rdata_vld <= 1'b0;
        end else begin
            req0_rdata_vld <= fwd0;
            req1_rdata_vld <= fwd1;
            if (fwd0)
                req0_rdata <= rdata;
            if (fwd1)
                req1_rdata <= rdata;
        end
    end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter with a small behavioural SCCB master.
// Cycle numbers are sampled one time unit after the falling edge.
`timescale 1ns/1ps
module tb_sccb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       req0_wr_en = 1'b0, req0_rd_en = 1'b0, req0_lock = 1'b0;
    logic [7:0] req0_addr = '0, req0_wdata = '0;
    logic       req0_rdy, req0_rdata_vld;
    logic [7:0] req0_rdata;

    logic       req1_wr_en = 1'b0, req1_rd_en = 1'b0;
    logic [7:0] req1_addr = '0, req1_wdata = '0;
    logic       req1_rdy, req1_rdata_vld;
    logic [7:0] req1_rdata;

    logic       wr_en, rd_en, err;
    logic [7:0] addr, wdata;
    logic       rdy = 1'b1;
    logic [7:0] rdata = '0;
    logic       rdata_vld = 1'b0;

    sccb_arbiter #(.START_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_wr_en     (req0_wr_en),
        .req0_rd_en     (req0_rd_en),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req0_lock      (req0_lock),
        .req0_rdy       (req0_rdy),
        .req0_rdata     (req0_rdata),
        .req0_rdata_vld (req0_rdata_vld),
        .req1_wr_en     (req1_wr_en),
        .req1_rd_en     (req1_rd_en),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .req1_rdy       (req1_rdy),
        .req1_rdata     (req1_rdata),
        .req1_rdata_vld (req1_rdata_vld),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .addr           (addr),
        .wdata          (wdata),
        .rdy            (rdy),
        .rdata          (rdata),
        .rdata_vld      (rdata_vld),
        .err            (err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Master: drops rdy after a command, busy 4 cycles, returns 0x76 on reads
    logic       m_stuck = 1'b0;
    int         m_busy = 0;
    logic       m_rd = 1'b0;
    int         m_rise_cyc = -1;
    int         m_vld_cyc = -1;
    int         m_cyc[$];
    logic       m_isrd[$];
    logic [7:0] m_addr[$];
    logic [7:0] m_wd[$];

    initial begin
        forever begin
            @(negedge clk);
            rdata_vld = 1'b0;
            if (rdy && (wr_en || rd_en)) begin
                m_cyc.push_back(cyc);
                m_isrd.push_back(rd_en);
                m_addr.push_back(addr);
                m_wd.push_back(wdata);
                if (!m_stuck) begin
                    rdy    = 1'b0;
                    m_busy = 4;
                    m_rd   = rd_en;
                end
            end else if (!rdy) begin
                m_busy--;
                if (m_busy == 1 && m_rd) begin
                    rdata     = 8'h76;
                    rdata_vld = 1'b1;
                    m_vld_cyc = cyc;
                end
                if (m_busy == 0) begin
                    rdy        = 1'b1;
                    m_rise_cyc = cyc;
                end
            end
        end
    end

    int         err_n = 0, err_cyc = -1;
    int         rv0_n = 0, rv1_n = 0, rv1_cyc = -1;
    logic [7:0] rv1_dat = '0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (err) begin
                err_n++;
                err_cyc = cyc;
            end
            if (req0_rdata_vld) rv0_n++;
            if (req1_rdata_vld) begin
                rv1_n++;
                rv1_cyc = cyc;
                rv1_dat = req1_rdata;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic rd, input logic [7:0] a, input logic [7:0] d);
        if (r == 0) begin
            req0_rd_en = rd; req0_wr_en = !rd; req0_addr = a; req0_wdata = d;
        end else begin
            req1_rd_en = rd; req1_wr_en = !rd; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic clr_reqs();
        req0_wr_en = 1'b0; req0_rd_en = 1'b0;
        req1_wr_en = 1'b0; req1_rd_en = 1'b0;
    endtask

    task automatic wait_cmds(input int n, input int budget);
        int k = 0;
        while (m_cyc.size() < n && k < budget) begin
            step();
            k++;
        end
        if (m_cyc.size() < n) chk("cmd_wait_timeout", m_cyc.size(), n);
    endtask

    task automatic wait_rdy(input int r, input int budget, output int at);
        int k = 0;
        while (((r == 0) ? !req0_rdy : !req1_rdy) && k < budget) begin
            step();
            k++;
        end
        at = cyc;
        if ((r == 0) ? !req0_rdy : !req1_rdy) chk("rdy_wait_timeout", 0, 1);
    endtask

    int t0, base, at, e0;

    initial begin
        // Reset values
        step(); step(); step();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_req0_rdy", req0_rdy, 1);
        chk("rst_req1_rdy", req1_rdy, 1);
        chk("rst_req0_vld", req0_rdata_vld, 0);
        chk("rst_req1_rdata", req1_rdata, 0);
        rst_n = 1'b1;
        step(); step();

        // First tie: req0 wins (last resets to 1); req1 read returns 0x76
        base = m_cyc.size();
        t0 = cyc;
        set_req(0, 1'b0, 8'h11, 8'h5A);
        set_req(1, 1'b1, 8'h0A, 8'h00);
        step(); clr_reqs();
        chk("tie1_req0_rdy", req0_rdy, 0);
        chk("tie1_req1_rdy", req1_rdy, 0);
        wait_cmds(base + 2, 60);
        chk("tie1_first_cyc", m_cyc[base], t0 + 2);
        chk("tie1_first_addr", m_addr[base], 8'h11);
        chk("tie1_first_wd", m_wd[base], 8'h5A);
        chk("tie1_first_isrd", m_isrd[base], 0);
        chk("tie1_second_cyc", m_cyc[base+1], t0 + 8);
        chk("tie1_second_addr", m_addr[base+1], 8'h0A);
        chk("tie1_second_isrd", m_isrd[base+1], 1);
        wait_rdy(1, 40, at);
        step(); step();
        chk("rd_vld_count", rv1_n, 1);
        chk("rd_vld_cyc", rv1_cyc, m_vld_cyc + 1);
        chk("rd_data", rv1_dat, 8'h76);
        chk("rd_req0_vld", rv0_n, 0);

        // Single write; a pulse while req0_rdy=0 is dropped
        base = m_cyc.size();
        t0 = cyc;
        set_req(0, 1'b0, 8'h12, 8'h80);
        step(); clr_reqs();
        chk("wr_rdy_low", req0_rdy, 0);
        set_req(0, 1'b0, 8'h13, 8'h33);
        step(); clr_reqs();
        wait_cmds(base + 1, 20);
        chk("wr_cyc", m_cyc[base], t0 + 2);
        chk("wr_pulse", wr_en, 1);
        chk("wr_addr", addr, 8'h12);
        chk("wr_wdata", wdata, 8'h80);
        chk("wr_isrd", m_isrd[base], 0);
        wait_rdy(0, 40, at);
        chk("wr_rdy_return", at, m_rise_cyc + 1);
        chk("wr_addr_held", addr, 8'h12);
        repeat (8) step();
        chk("drop_not_issued", m_cyc.size(), base + 1);

        // Second tie after req0 completed last: req1 wins
        base = m_cyc.size();
        t0 = cyc;
        set_req(0, 1'b0, 8'h22, 8'h01);
        set_req(1, 1'b0, 8'h33, 8'h02);
        step(); clr_reqs();
        wait_cmds(base + 2, 60);
        chk("tie2_first_addr", m_addr[base], 8'h33);
        chk("tie2_first_cyc", m_cyc[base], t0 + 2);
        chk("tie2_second_addr", m_addr[base+1], 8'h22);
        chk("tie2_second_cyc", m_cyc[base+1], t0 + 8);
        wait_rdy(0, 40, at);
        step(); step();

        // Lock: req1 held off across three req0 writes
        req0_lock = 1'b1;
        step();
        base = m_cyc.size();
        set_req(1, 1'b0, 8'h44, 8'hAA);
        step(); clr_reqs();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b0, 8'h50 + 8'(i), 8'(i));
            step(); clr_reqs();
            wait_rdy(0, 40, at);
        end
        step(); step(); step();
        chk("lock_count", m_cyc.size(), base + 3);
        for (int i = 0; i < 3; i++)
            chk("lock_addr", m_addr[base+i], 8'h50 + 8'(i));
        chk("lock_req1_pending", req1_rdy, 0);
        t0 = cyc;
        req0_lock = 1'b0;
        wait_cmds(base + 4, 20);
        chk("unlock_cyc", m_cyc[base+3], t0 + 1);
        chk("unlock_addr", m_addr[base+3], 8'h44);
        wait_rdy(1, 40, at);
        step(); step();

        // Start timeout: master never drops rdy
        m_stuck = 1'b1;
        base = m_cyc.size();
        e0 = err_n;
        set_req(0, 1'b0, 8'h66, 8'h00);
        step(); clr_reqs();
        wait_cmds(base + 1, 20);
        for (int k = 0; k < 40 && err_n == e0; k++) step();
        chk("tmo_err_cyc", err_cyc, m_cyc[base] + 17);
        wait_rdy(0, 40, at);
        chk("tmo_rdy_return", at, err_cyc + 1);
        step(); step(); step();
        chk("tmo_err_single", err_n, e0 + 1);
        m_stuck = 1'b0;
        t0 = cyc;
        set_req(0, 1'b0, 8'h67, 8'h00);
        step(); clr_reqs();
        wait_cmds(base + 2, 20);
        chk("post_tmo_cyc", m_cyc[base+1], t0 + 2);
        chk("post_tmo_addr", m_addr[base+1], 8'h67);
        wait_rdy(0, 40, at);
        step(); step();

        // Reset while waiting for completion
        base = m_cyc.size();
        set_req(0, 1'b0, 8'h70, 8'hC3);
        step(); clr_reqs();
        wait_cmds(base + 1, 20);
        step(); step();
        chk("mid_master_busy", rdy, 0);
        e0 = err_n;
        rst_n = 1'b0;
        step();
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_req0_rdy", req0_rdy, 1);
        chk("mid_rst_req1_rdy", req1_rdy, 1);
        step(); step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("mid_rst_no_reissue", m_cyc.size(), base + 1);
        chk("mid_rst_no_err", err_n, e0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Shares the single SCCB master between two register-access requesters: requester 0 is the OV7670 power-up configuration engine, requester 1 is the runtime register port (key-driven exposure/gain tweaks, debug reads). Each requester sees a private copy of the master's command/ready/read-data handshake. The arbiter buffers one command per requester, grants round-robin (or locked to requester 0 during configuration), and routes read data back to the owner. It sits between the config/tuning logic and the SCCB master in the camera front end.

## Interface
- START_TIMEOUT, 16: cycles to wait for master `rdy` to fall after a command pulse before aborting
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req0_wr_en / req0_rd_en  in  1  one-cycle command pulse from requester 0, valid only while req0_rdy=1
- req0_addr / req0_wdata  in  8  register address / write data, sampled with the pulse
- req0_lock  in  1  level; while high only requester 0 is granted
- req0_rdy  out  1  slot 0 empty, may accept a command
- req0_rdata  out  8  read data to requester 0
- req0_rdata_vld  out  1  one-cycle read-data strobe to requester 0
- req1_* (wr_en, rd_en, addr, wdata, rdy, rdata, rdata_vld)  same as requester 0, no lock input
- wr_en / rd_en  out  1  one-cycle command pulse to SCCB master
- addr / wdata  out  8  command fields to master, held stable from pulse until completion
- rdy  in  1  master idle
- rdata / rdata_vld  in  8 / 1  master read data and one-cycle strobe
- err  out  1  one-cycle pulse on start timeout

## Operation
- Per-requester slot: `pending`, `is_rd`, addr, wdata. Pulse with reqN_rdy=1 latches slot, pending=1. Pulse with reqN_rdy=0 is dropped. wr_en and rd_en together -> write.
- reqN_rdy = !pendingN.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE: if master rdy=1 and any eligible pending slot, select owner, load addr/wdata -> ISSUE. Eligible: slot 0 always; slot 1 only when req0_lock=0.
- Selection: only one eligible -> it; both -> the one not granted last (`last` register, reset to 1 so requester 0 wins first tie).
- ISSUE: drive wr_en or rd_en for exactly one cycle, clear timeout counter -> WAIT_START.
- WAIT_START: rdy=0 -> WAIT_DONE; counter reaches START_TIMEOUT -> pulse err, clear owner's pending, -> IDLE.
- WAIT_DONE: rdy=1 -> clear owner's pending, update `last`, -> IDLE.
- rdata_vld from master forwarded (registered) to owner only; other requester's rdata_vld stays 0. rdata_vld outside WAIT_START/WAIT_DONE is ignored.
- Lock asserted mid-transaction of requester 1: transaction completes; later requester 1 grants blocked until lock=0; its pending is kept.
- A new command from the owner is accepted in the cycle after its rdy rises, never earlier.

## Timing
- Reset values: wr_en=0, rd_en=0, addr=0, wdata=0, err=0, reqN_rdata=0, reqN_rdata_vld=0, pending=0 (reqN_rdy=1), state=IDLE, last=1.
- Request pulse at cycle T -> reqN_rdy=0 at T+1 -> master pulse at T+2 (master idle, no contention). Minimum request-to-master latency 2 cycles.
- Master rdy rising at cycle D -> reqN_rdy=1 at D+1; IDLE at D+1, next grant possible at D+1, pulse at D+2.
- Master rdata_vld at cycle V -> reqN_rdata_vld and reqN_rdata at V+1.
- Simultaneous accept into a slot and completion of the other slot: both take effect in the same cycle.
- Timeout counter width $clog2(START_TIMEOUT+1); err at cycle issue+1+START_TIMEOUT.
- Reset mid-operation: all slots cleared, in-flight command abandoned, no err.

## Structure
- Package sccb_arb_pkg: FSM state encoding, SCCB address/data width constant (8), requester index constants.
- Sub-module sccb_req_slot (one-entry command buffer with pending flag and accept logic), instantiated twice; arbiter FSM, round-robin and timeout in top.

## Test plan
- Single write, req0 addr=0x12 wdata=0x80 at T -> wr_en pulse at T+2 with addr=0x12/wdata=0x80, req0_rdy low until cycle after master rdy rises.
- Both requesters pulse same cycle (req0 wr 0x11, req1 rd 0x0A) -> req0 granted first, req1 issued after req0 completes; second tie grants req1 first.
- req0_lock=1 with req1 pending -> no req1 grant across three req0 writes; lock drop -> req1 issued next IDLE.
- req1 read 0x0A, master returns rdata=0x76 -> req1_rdata_vld pulse with 0x76 one cycle later; req0_rdata_vld stays 0.
- Master holds rdy=1 after pulse -> err pulse at issue+1+16, owner rdy returns 1, next command proceeds normally.
- Pulse while reqN_rdy=0 and rst_n low mid-WAIT_DONE -> dropped command never issued; after reset all outputs at reset values.
